// File: rtl/bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_addsub
// Brief    : Bit-serial adder/subtractor. Processes one operand bit per clock,
//            LSB first, and produces the dw-bit result plus carry-out and
//            two's-complement overflow flags after dw cycles.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_addsub #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [dw-1:0] dataa,
  input  logic [dw-1:0] datab,
  input  logic          add_sub,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] result,
  output logic          cout,
  output logic          ovf
);

  // Counter only needs to span 0..dw-1; it never wraps within an operation.
  localparam int CW = (dw > 1) ? $clog2(dw) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(dw - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  // Operand shift registers: bit 0 always holds the bit being processed.
  logic [dw-1:0]   a_sh;
  logic [dw-1:0]   b_sh;
  // Partial sum, filled in place at the position given by the bit counter.
  logic [dw-1:0]   sum_sh;
  logic [dw-1:0]   sum_nx;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            last_bit;
  logic            sum_bit;
  logic            carry_nx;

  // Control decode and one full-adder slice of serial arithmetic.
  always_comb begin
    accept   = 1'b0;
    last_bit = 1'b0;
    sum_bit  = 1'b0;
    carry_nx = 1'b0;
    sum_nx   = sum_sh;

    accept   = start && ((state == IDLE) || (state == DONE));
    last_bit = (state == RUN) && (cnt == LAST_BIT);

    sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    sum_nx[cnt] = sum_bit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: start is honoured in IDLE and DONE only, so a request
  // made while RUN is simply dropped rather than queued.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = RUN;
      end
      RUN: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        if (accept) state_nx = RUN;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and bit-serial datapath. Subtraction is handled as
  // dataa + ~datab + 1, so the operation is fully encoded in the inverted
  // operand and the initial carry; add_sub need not be kept separately.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= dataa;
      b_sh   <= add_sub ? datab : ~datab;
      sum_sh <= '0;
      carry  <= ~add_sub;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nx;
      carry  <= carry_nx;
      if (!last_bit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Visible results change only at the edge that finishes the MSB. Signed
  // overflow is the carry into the MSB differing from the carry out of it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (last_bit) begin
      result <= sum_nx;
      cout   <= carry_nx;
      ovf    <= carry ^ carry_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_addsub
// Brief    : Directed self-checking bench for bit_serial_addsub (dw = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_addsub;

  localparam int DW = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [DW-1:0] dataa;
  logic [DW-1:0] datab;
  logic          add_sub;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          cout;
  logic          ovf;

  int n_cmp;
  int n_err;

  // Expected value of the held outputs, tracked from the bench's own vectors.
  logic [DW-1:0] exp_res;
  logic          exp_cout;
  logic          exp_ovf;

  bit_serial_addsub #(.dw(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .add_sub (add_sub),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expect quiescent IDLE outputs in the current (negedge-sampled) cycle.
  task automatic expect_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " res"},  32'(result), 32'(exp_res));
  endtask

  // Called at a negedge: raises start with the operands, then follows the
  // operation through its 8 RUN cycles and returns at the negedge of the
  // DONE cycle with start low. Operands are scrambled during RUN; when
  // inject is set, a second start is pulsed mid-run and must be ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic op, input logic [7:0] r, input logic c,
                        input logic v, input bit inject);
    start   = 1'b1;
    dataa   = a;
    datab   = b;
    add_sub = op;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      start   = 1'b0;
      dataa   = ~a;
      datab   = b ^ 8'h5A;
      add_sub = ~op;
      if (inject && i == 3) begin
        start   = 1'b1;
        dataa   = 8'h10;
        datab   = 8'h10;
        add_sub = 1'b1;
      end
      check({tag, " run busy"}, 32'(busy), 32'd1);
      check({tag, " run done"}, 32'(done), 32'd0);
      check({tag, " run hold"}, {22'd0, ovf, cout, result}, {22'd0, exp_ovf, exp_cout, exp_res});
    end
    @(negedge clk);
    start = 1'b0;
    exp_res  = r;
    exp_cout = c;
    exp_ovf  = v;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " res"},  32'(result), 32'(r));
    check({tag, " cout"}, 32'(cout), 32'(c));
    check({tag, " ovf"},  32'(ovf), 32'(v));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_res  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    reset_n  = 1'b0;
    start    = 1'b1;
    dataa    = 8'hAA;
    datab    = 8'h55;
    add_sub  = 1'b1;

    // Reset overrides start.
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst res",  32'(result), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf",  32'(ovf), 32'd0);
    reset_n = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    expect_idle("post-rst");

    run_op("add 05+03", 8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_idle("idle1");

    run_op("add FF+01", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run_op("add 7F+01", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    run_op("sub 03-05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_op("sub 80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    run_op("sub 55-55", 8'h55, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run_op("add 80+80", 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Start pulsed while busy must not queue a second operation.
    run_op("inj 05+03", 8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("inj no-rerun busy", 32'(busy), 32'd0);
      check("inj no-rerun done", 32'(done), 32'd0);
    end
    check("inj res kept", 32'(result), 32'h08);

    // Back-to-back: start asserted during the DONE cycle.
    run_op("b2b 7F+01", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("b2b 20-01", 8'h20, 8'h01, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_idle("idle b2b");

    // Reset during the 4th RUN cycle aborts the operation.
    start   = 1'b1;
    dataa   = 8'h11;
    datab   = 8'h22;
    add_sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort pre busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    exp_res  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort res",  32'(result), 32'd0);
    check("abort flags", {30'd0, ovf, cout}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort no done", 32'(done), 32'd0);
    end

    // Operation after the abort still works.
    run_op("post-abort 05+03", 8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_idle("final idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
